es8psk_tx_shaper: RTL and testbench
===================================

Name: es8psk_tx_shaper

Overview:
- Transmit-side pulse-shaping interpolator for the 8PSK modem; one instance per I or Q rail.
- Accepts one symbol-amplitude word every L clocks through a valid/ready handshake.
- Zero-stuffs by L and filters with a 24-tap symmetric polyphase FIR, emitting one shaped sample per clock toward the DAC path.
- Coefficients are fixed and share Q18 scaling with the receive filter, so TX+RX form the matched pair.

Parameters:
- W, 20, symbol and output sample width, signed two's complement.
- L, 4, interpolation factor; fixed at 4 because package taps assume N=24=6*L.

Ports:
- clk  in  1  system clock, one output sample per cycle
- reset_b  in  1  asynchronous active-low reset
- sym_data  in  W  signed symbol amplitude
- sym_valid  in  1  sym_data valid
- sym_ready  out  1  block takes a symbol this cycle
- data_output  out  W  signed shaped sample
- out_valid  out  1  data_output meaningful (pipeline filled)
- out_phase  out  2  polyphase index p of data_output
- underflow  out  1  one-cycle pulse: symbol slot had no valid symbol

Behaviour:
- Reset (async, reset_b low): phase counter ph=0, delay line d[0..5]=0, pipeline regs=0, data_output=0, out_valid=0, out_phase=0, underflow=0, sym_ready=0.
- ph counts 0,1,2,3,0,... every clk after reset release.
- sym_ready = (ph==L-1), combinational from ph, so it is high one cycle in every L.
- Symbol slot (edge where ph==L-1):
  - sym_valid=1: d shifts, d[0]<=sym_data (handshake completes).
  - sym_valid=0: d shifts, d[0]<=0, underflow<=1 for one cycle.
  - sym_valid is ignored outside a slot; the source holds data until it sees ready.
- Phase p output: y = sum over k=0..5 of h[k*L+p]*d[k].
  - Product width is W+WC+1 (WC=18).
  - Accumulator width is W+WC+3; wrap is impossible.
- Pipeline:
  - Edge E+1 registers the six products and the phase tag.
  - The sum is combinational.
  - Edge E+2 registers data_output.
  - Latency: the phase-0 output containing a symbol accepted at edge E appears after edge E+2. Phases 1..3 follow on consecutive clocks.
- Rounding: data_output = acc[W+WC-1:WC] + acc[WC-1] (round half up, truncate to W). The coefficient gain keeps the result in range for any legal input.
- out_valid rises after the 3rd clk edge following reset release and stays high. out_phase carries the p that produced data_output.
- Reset mid-stream clears everything immediately. After release, behaviour is identical to power-up: ph restarts at 0, so the first slot is the 4th edge.
- Simultaneous underflow and reset: reset wins, and underflow stays 0.

Optional Feature:
- Macro: TX_SHAPER_UFLOW_CNT_EN.
- Defined:
  - Adds output uflow_cnt [15:0], counting underflow pulses.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package es8psk_tx_pkg holds:
  - WC=18 and N=24.
  - Coefficient constants h[0..11] = 454, -342, -1479, -1138, 2580, 6289, 2017, -11143, -18470, -1403, 38404, 72928.
  - The symmetry rule h[i]=h[23-i].
  - A function returning tap h[k*L+p].
- One sub-module, es8psk_tx_poly_mac: given d[0..5] and p, it registers six products and outputs the rounded W-bit sum. The top level keeps the phase counter, handshake, delay line and flags.

Test Plan:
- Impulse: sym_data=1000 on one slot, 0 on all others -> 24 outputs after latency equal round(1000*h[n]/2^18), n=0..23.
  - Checkpoints: n=0 -> 2, n=1 -> -1, n=11 -> 278, n=12 -> 278, n=23 -> 2.
- DC: sym_data=100000 held with sym_valid=1 -> steady state phase0=17247, phase1=16589, phase2=16589, phase3=17247.
- Handshake: sym_valid high continuously -> sym_ready high only when ph==3, so exactly one accept per 4 clocks. Random sym_valid gaps -> underflow pulse in each gap slot, and a zero is inserted (impulse response truncated accordingly).
- Reset mid-stream: assert reset_b low during DC steady state -> data_output, out_valid and underflow go 0 asynchronously. After release, out_valid returns after 3 edges and the first sym_ready is at the 4th edge.
- Negative full scale: sym_data=-(2^19) held -> phase0 = round(-524288*45211/2^18) = -90422, with no wrap.
- With TX_SHAPER_UFLOW_CNT_EN: 10 empty slots -> uflow_cnt=10. Forcing the counter to 16'hFFFF then one more empty slot -> uflow_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/es8psk_tx_pkg.sv
// es8psk_tx_pkg
//   Shared constants for the 8PSK transmit pulse-shaping interpolator.
//   Holds the coefficient scaling (Q18, WC=18), the prototype filter length
//   (N=24 taps), and the first half of the symmetric tap set.
//   tap_coef() returns the tap that multiplies delay-line entry k while
//   polyphase p is being produced, i.e. h[k*L+p].
//   The taps are laid out for an interpolation factor of 4, which gives 6 taps
//   per phase.
package es8psk_tx_pkg;

  localparam int WC = 18;          // coefficient fraction bits (Q18)
  localparam int N  = 24;          // prototype filter length
  localparam int LP = 4;           // interpolation factor the taps are laid out for
  localparam int NT = N / LP;      // taps per polyphase branch (delay-line depth)
  localparam int NH = N / 2;       // stored half of the symmetric response

  // First half of the impulse response. The second half mirrors it:
  // h[i] = h[N-1-i]. The receive filter uses the same Q18 scaling, so the
  // transmit and receive filters form a matched pair.
  localparam logic signed [WC:0] H_HALF [0:NH-1] = '{
    19'sd454,   -19'sd342,   -19'sd1479,  -19'sd1138,
    19'sd2580,   19'sd6289,   19'sd2017,  -19'sd11143,
    -19'sd18470, -19'sd1403,  19'sd38404,  19'sd72928
  };

  // Returns h[k*LP+p], folding the upper half back onto the stored half.
  function automatic logic signed [WC:0] tap_coef(input logic [2:0] k,
                                                  input logic [1:0] p);
    logic [4:0] i;
    logic [3:0] j;
    i = {k, 2'b00} + {3'b000, p};
    if (i > 5'd11) begin
      i = 5'd23 - i;
    end
    j = i[3:0];
    return H_HALF[j];
  endfunction

endpackage

// File: rtl/es8psk_tx_poly_mac.sv
// es8psk_tx_poly_mac
//   Polyphase multiply-accumulate for the transmit shaper.
//   On every clock it multiplies the six delay-line entries by the taps of
//   the requested phase and registers the six products along with the phase
//   tag. The products are summed combinationally. The sum is then rounded
//   half-up to W bits.
// Ports
//   clk      in   system clock
//   reset_b  in   asynchronous active-low reset
//   d        in   delay line, d[0] is the newest symbol (signed W-bit entries)
//   phase    in   polyphase index p to compute this cycle
//   y        out  rounded W-bit sum of the registered products
//   y_phase  out  phase tag that belongs to y
module es8psk_tx_poly_mac
  import es8psk_tx_pkg::*;
#(
  parameter int W = 20
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [NT-1:0][W-1:0] d,
  input  logic [1:0]           phase,
  output logic [W-1:0]         y,
  output logic [1:0]           y_phase
);

  localparam int PW = W + WC + 1;  // product width
  localparam int AW = W + WC + 3;  // accumulator width; six terms cannot wrap it

  logic [NT-1:0][WC:0]   coef;
  logic [NT-1:0][PW-1:0] prod_next;
  logic [NT-1:0][PW-1:0] prod_reg;
  logic [1:0]            phase_reg;
  logic signed [AW-1:0]  acc;
  logic                  unused_acc_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_tap
      assign coef[gi]      = tap_coef(3'(gi), phase);
      assign prod_next[gi] = PW'($signed(d[gi])) * PW'($signed(coef[gi]));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      prod_reg  <= '0;
      phase_reg <= 2'd0;
    end else begin
      prod_reg  <= prod_next;
      phase_reg <= phase;
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NT; k++) begin
      acc = acc + AW'($signed(prod_reg[k]));
    end
  end

  // Round half up: keep the integer part, then add the first dropped bit.
  // The coefficient gain keeps legal inputs in range, so the top guard bits
  // are not needed.
  assign y       = acc[W+WC-1:WC] + W'(acc[WC-1]);
  assign y_phase = phase_reg;

  assign unused_acc_bits = ^{acc[AW-1:W+WC], acc[WC-2:0]};

endmodule

// File: rtl/es8psk_tx_shaper.sv
// es8psk_tx_shaper
//   Transmit pulse-shaping interpolator for one rail (I or Q) of the 8PSK
//   modem. The block takes one symbol every L clocks. It zero-stuffs by L and
//   runs a 24-tap symmetric polyphase FIR, which gives one shaped sample per
//   clock.
//   Optional build macro TX_SHAPER_UFLOW_CNT_EN adds a saturating 16-bit count
//   of underflow pulses on port uflow_cnt.
// Ports
//   clk          in   system clock, one output sample per cycle
//   reset_b      in   asynchronous active-low reset
//   sym_data     in   signed symbol amplitude
//   sym_valid    in   sym_data valid
//   sym_ready    out  a symbol is taken at the end of this cycle (ph==L-1)
//   data_output  out  signed shaped sample
//   out_valid    out  pipeline has filled; high from the 3rd edge after reset
//   out_phase    out  polyphase index that produced data_output
//   underflow    out  one-cycle pulse: a symbol slot passed with no valid symbol
//   uflow_cnt    out  (TX_SHAPER_UFLOW_CNT_EN only) saturating underflow count
module es8psk_tx_shaper
  import es8psk_tx_pkg::*;
#(
  parameter int W = 20,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [W-1:0] sym_data,
  input  logic         sym_valid,
  output logic         sym_ready,
  output logic [W-1:0] data_output,
  output logic         out_valid,
  output logic [1:0]   out_phase,
  output logic         underflow
`ifdef TX_SHAPER_UFLOW_CNT_EN
  ,
  output logic [15:0]  uflow_cnt
`endif
);

  logic [1:0]           ph_reg;
  logic [1:0]           ph_next;
  logic                 slot;
  logic [NT-1:0][W-1:0] d_reg;
  logic [NT-1:0][W-1:0] d_next;
  logic [1:0]           fill_cnt_reg;
  logic                 out_valid_reg;
  logic [W-1:0]         data_output_reg;
  logic [1:0]           out_phase_reg;
  logic                 underflow_reg;
  logic                 underflow_next;
  logic [W-1:0]         mac_y;
  logic [1:0]           mac_phase;

  // Phase counter: the symbol slot is the last phase of each group of L.
  assign slot    = (ph_reg == 2'(L - 1));
  assign ph_next = slot ? 2'd0 : ph_reg + 2'd1;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ph_reg <= 2'd0;
    end else begin
      ph_reg <= ph_next;
    end
  end

  assign sym_ready = slot;

  // Delay line shifts only in a slot. An empty slot shifts in a zero so the
  // filter timing stays locked to the symbol grid.
  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_dline
      if (gi == 0) begin : g_head
        assign d_next[gi] = !slot     ? d_reg[gi] :
                            sym_valid ? sym_data  : '0;
      end else begin : g_tail
        assign d_next[gi] = slot ? d_reg[gi-1] : d_reg[gi];
      end
    end
  endgenerate

  assign underflow_next = slot && !sym_valid;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      d_reg         <= '0;
      underflow_reg <= 1'b0;
    end else begin
      d_reg         <= d_next;
      underflow_reg <= underflow_next;
    end
  end

  es8psk_tx_poly_mac #(
    .W (W)
  ) u_mac (
    .clk     (clk),
    .reset_b (reset_b),
    .d       (d_reg),
    .phase   (ph_reg),
    .y       (mac_y),
    .y_phase (mac_phase)
  );

  // Output register, plus the fill tracker. out_valid sets on the third edge
  // after reset and then stays high.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      data_output_reg <= '0;
      out_phase_reg   <= 2'd0;
      fill_cnt_reg    <= 2'd0;
      out_valid_reg   <= 1'b0;
    end else begin
      data_output_reg <= mac_y;
      out_phase_reg   <= mac_phase;
      if (fill_cnt_reg != 2'd3) begin
        fill_cnt_reg <= fill_cnt_reg + 2'd1;
      end
      out_valid_reg <= out_valid_reg | (fill_cnt_reg == 2'd2);
    end
  end

  assign data_output = data_output_reg;
  assign out_phase   = out_phase_reg;
  assign out_valid   = out_valid_reg;
  assign underflow   = underflow_reg;

`ifdef TX_SHAPER_UFLOW_CNT_EN
  logic [15:0] uflow_cnt_reg;

  // Saturating count: it holds at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      uflow_cnt_reg <= 16'd0;
    end else if (underflow_next && (uflow_cnt_reg != 16'hFFFF)) begin
      uflow_cnt_reg <= uflow_cnt_reg + 16'd1;
    end
  end

  assign uflow_cnt = uflow_cnt_reg;
`endif

endmodule

// File: tb/tb_es8psk_tx_shaper.sv
// tb_es8psk_tx_shaper
//   Directed bench for es8psk_tx_shaper. It runs an impulse with an empty
//   slot, then a DC level, then a mid-stream reset, then negative full scale.
//   When TX_SHAPER_UFLOW_CNT_EN is defined it also checks the underflow count.
module tb_es8psk_tx_shaper;

  localparam int W = 20;

  logic         clk;
  logic         reset_b;
  logic [W-1:0] sym_data;
  logic         sym_valid;
  logic         sym_ready;
  logic [W-1:0] data_output;
  logic         out_valid;
  logic [1:0]   out_phase;
  logic         underflow;
`ifdef TX_SHAPER_UFLOW_CNT_EN
  logic [15:0]  uflow_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;   // clock edges since the last reset release

  // round(1000*h[n]/2^18), round half up, n = 0..11 (upper half mirrors)
  int imp_tab [0:11] = '{2, -1, -6, -4, 10, 24, 8, -43, -70, -5, 146, 278};
  // steady-state outputs per phase
  int dc_tab  [0:3]  = '{17247, 16589, 16589, 17247};   // sym = 100000
  int neg_tab [0:3]  = '{-90422, -86972, -86972, -90422}; // sym = -2^19

  es8psk_tx_shaper #(
    .W (W),
    .L (4)
  ) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .sym_data    (sym_data),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .data_output (data_output),
    .out_valid   (out_valid),
    .out_phase   (out_phase),
    .underflow   (underflow)
`ifdef TX_SHAPER_UFLOW_CNT_EN
    ,
    .uflow_cnt   (uflow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0d expected %0d", tag, ecount, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  // Drive the inputs for the next edge. In a slot, the given values go out.
  // Outside a slot, junk goes out, and the DUT must ignore it.
  task automatic drive_slot(input logic v, input logic [W-1:0] val);
    if (((ecount + 1) % 4) == 0) begin
      sym_valid = v;
      sym_data  = val;
    end else begin
      sym_valid = 1'($urandom_range(0, 1));
      sym_data  = W'($urandom());
    end
  endtask

  task automatic check_ready();
    check_eq("sym_ready", int'(sym_ready), int'((ecount % 4) == 3));
  endtask

  // Asserts reset between edges and checks that the outputs clear at once.
  // Release also lands between edges, and the edge count restarts from zero.
  task automatic apply_reset();
    reset_b = 1'b0;
    #1;
    check_eq("rst_data_output", int'($signed(data_output)), 0);
    check_eq("rst_out_valid",   int'(out_valid), 0);
    check_eq("rst_out_phase",   int'(out_phase), 0);
    check_eq("rst_underflow",   int'(underflow), 0);
    check_eq("rst_sym_ready",   int'(sym_ready), 0);
    repeat (2) @(posedge clk);
    #3;
    reset_b = 1'b1;
    ecount  = 0;
  endtask

  initial begin
    int idx;
    int j;
    int accepts;

    reset_b   = 1'b1;
    sym_valid = 1'b0;
    sym_data  = '0;
    #2;

    // Impulse: 1000 in slot 1, an empty slot 2 (junk data must not be taken),
    // and zeros after that.
    apply_reset();
    for (int n = 1; n <= 32; n++) begin
      if (n == 4)      drive_slot(1'b1, W'(1000));
      else if (n == 8) drive_slot(1'b0, W'(777));
      else             drive_slot(1'b1, '0);
      step();
      check_ready();
      if (n == 2) check_eq("fill_out_valid_e2", int'(out_valid), 0);
      if (n == 3) check_eq("fill_out_valid_e3", int'(out_valid), 1);
      if (n == 5) check_eq("imp_pre", int'($signed(data_output)), 0);
      if (n >= 6 && n <= 29) begin
        idx = n - 6;
        j   = (idx > 11) ? 23 - idx : idx;
        check_eq($sformatf("imp_n%0d", idx), int'($signed(data_output)), imp_tab[j]);
        check_eq($sformatf("imp_phase_n%0d", idx), int'(out_phase), idx % 4);
      end
      if (n == 30) check_eq("imp_post", int'($signed(data_output)), 0);
      if (n == 4 || n == 8 || n == 9)
        check_eq($sformatf("imp_underflow_e%0d", n), int'(underflow), int'(n == 8));
    end

    // DC level with sym_valid held at every slot: one accept per 4 clocks.
    apply_reset();
    accepts = 0;
    for (int n = 1; n <= 45; n++) begin
      drive_slot(1'b1, W'(100000));
      if (sym_ready && sym_valid) accepts++;
      step();
      check_ready();
      if (n >= 38) begin
        check_eq($sformatf("dc_e%0d", n), int'($signed(data_output)), dc_tab[(n - 2) % 4]);
        check_eq($sformatf("dc_phase_e%0d", n), int'(out_phase), (n - 2) % 4);
      end
      if (n == 44) check_eq("dc_underflow", int'(underflow), 0);
    end
    check_eq("dc_accepts", accepts, 11);

    // Reset in the middle of the DC steady state, then negative full scale.
    apply_reset();
    for (int n = 1; n <= 41; n++) begin
      drive_slot(1'b1, W'(20'h80000));
      step();
      check_ready();
      if (n == 2) check_eq("rst2_out_valid_e2", int'(out_valid), 0);
      if (n == 3) check_eq("rst2_out_valid_e3", int'(out_valid), 1);
      if (n >= 38) begin
        check_eq($sformatf("neg_e%0d", n), int'($signed(data_output)), neg_tab[(n - 2) % 4]);
        check_eq($sformatf("neg_phase_e%0d", n), int'(out_phase), (n - 2) % 4);
      end
    end

`ifdef TX_SHAPER_UFLOW_CNT_EN
    // Ten empty slots, then saturation at all-ones.
    apply_reset();
    for (int n = 1; n <= 40; n++) begin
      drive_slot(1'b0, '0);
      step();
    end
    check_eq("uflow_cnt_10", int'(uflow_cnt), 10);
    force dut.uflow_cnt_reg = 16'hFFFF;
    #1;
    release dut.uflow_cnt_reg;
    for (int n = 41; n <= 44; n++) begin
      drive_slot(1'b0, '0);
      step();
    end
    check_eq("uflow_pulse_sat", int'(underflow), 1);
    check_eq("uflow_cnt_sat", int'(uflow_cnt), 65535);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
